// File: rtl/midi_pkg.sv
// Shared MIDI allocator definitions: field widths, voice limit, FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package midi_pkg;

    localparam int NOTE_W     = 7;
    localparam int VEL_W      = 7;
    localparam int MAX_VOICES = 16;

    typedef logic [NOTE_W-1:0] note_t;
    typedef logic [VEL_W-1:0]  vel_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_FLUSH  = 2'd3
    } alloc_state_t;

endpackage

// File: rtl/voice_age_tracker.sv
// Voice age ranking: rank 0 = oldest, NUM_VOICES-1 = newest, always a permutation.
// Latency: promote/reset_order take effect on the next clock; oldest index is combinational.
// Backpressure: none, strobes are accepted every cycle (reset_order wins over promote).
//
// Ports:
//   i_clk, i_rst       clock, async active-high reset (ranks -> identity)
//   i_promote          make voice i_promote_idx the newest
//   i_promote_idx      voice being promoted
//   i_reset_order      restore rank[i] = i
//   o_oldest_idx       voice currently holding rank 0
module voice_age_tracker #(
    parameter int NUM_VOICES = 4,
    parameter int VW         = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_promote,
    input  logic [VW-1:0] i_promote_idx,
    input  logic          i_reset_order,
    output logic [VW-1:0] o_oldest_idx
);

    logic [VW-1:0] r_rank [NUM_VOICES];
    logic [VW-1:0] w_old_rank;

    assign w_old_rank = r_rank[i_promote_idx];

    // Promotion: target jumps to newest, everyone younger than it shifts down one,
    // which keeps the ranks a permutation.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_rank[i] <= VW'(i);
            end
        end else if (i_reset_order) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_rank[i] <= VW'(i);
            end
        end else if (i_promote) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (VW'(i) == i_promote_idx) begin
                    r_rank[i] <= VW'(NUM_VOICES - 1);
                end else if (r_rank[i] > w_old_rank) begin
                    r_rank[i] <= r_rank[i] - VW'(1);
                end
            end
        end
    end

    always_comb begin
        o_oldest_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (r_rank[i] == '0) begin
                o_oldest_idx = VW'(i);
            end
        end
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// Polyphonic voice allocator: maps note-on/off events onto DDS voice slots (match, free, else steal oldest).
// Latency: event accepted at cycle 0, cfg write visible at cycle NUM_VOICES+1, ready again at NUM_VOICES+2.
// Backpressure: o_ev_ready low while scanning/committing/flushing; all_off in IDLE ignores a presented event.
//
// Ports:
//   i_sys_clk, i_rst                  clock, async active-high reset
//   i_ev_valid/o_ev_ready             event handshake; i_ev_note_on, i_ev_note, i_ev_vel carry the event
//   i_all_off                         level-sensed panic, releases every voice
//   o_cfg_valid + o_cfg_voice/note/vel/gate   one-cycle voice bank write, fields held between writes
//   o_voice_active                    per-slot sounding flags
//   o_steal_pulse                     one-cycle flag on a commit that stole an active voice
module midi_voice_allocator
    import midi_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int VW         = 2
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rst,
    input  logic                  i_ev_valid,
    output logic                  o_ev_ready,
    input  logic                  i_ev_note_on,
    input  logic [NOTE_W-1:0]     i_ev_note,
    input  logic [VEL_W-1:0]      i_ev_vel,
    input  logic                  i_all_off,
    output logic                  o_cfg_valid,
    output logic [VW-1:0]         o_cfg_voice,
    output logic [NOTE_W-1:0]     o_cfg_note,
    output logic [VEL_W-1:0]      o_cfg_vel,
    output logic                  o_cfg_gate,
    output logic [NUM_VOICES-1:0] o_voice_active,
    output logic                  o_steal_pulse
);

    alloc_state_t r_state, w_state_nxt;

    logic w_ev_ready, w_latch, w_scan, w_decide, w_flush_wr;
    logic w_last_idx;

    logic [VW-1:0]         r_idx;
    logic                  r_ev_on;
    note_t                 r_ev_note;
    vel_t                  r_ev_vel;
    logic                  r_match_found, r_free_found;
    logic [VW-1:0]         r_match_idx, r_free_idx;
    logic [NUM_VOICES-1:0] r_active;
    note_t                 r_note [NUM_VOICES];

    logic                  r_cfg_valid, r_cfg_gate, r_steal;
    logic [VW-1:0]         r_cfg_voice;
    note_t                 r_cfg_note;
    vel_t                  r_cfg_vel;

    logic                  w_cur_match, w_cur_free, w_any_match, w_any_free, w_steal;
    logic [VW-1:0]         w_match_sel, w_free_sel, w_target, w_oldest;

    assign w_last_idx = (r_idx == VW'(NUM_VOICES - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ev_ready  = 1'b0;
        w_latch     = 1'b0;
        w_scan      = 1'b0;
        w_decide    = 1'b0;
        w_flush_wr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ev_ready = 1'b1;
                // Panic outranks a pending event; the event stays on the bus.
                if (i_all_off) begin
                    w_state_nxt = ST_FLUSH;
                end else if (i_ev_valid) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_scan = 1'b1;
                if (w_last_idx) begin
                    w_decide    = 1'b1;
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
            end
            ST_FLUSH: begin
                w_flush_wr = 1'b1;
                if (w_last_idx) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ---------------- scan / decision ----------------
    // The final scan cycle folds in the voice under examination so the registered
    // write lands exactly in the COMMIT cycle.
    assign w_cur_match = r_active[r_idx] && (r_note[r_idx] == r_ev_note);
    assign w_cur_free  = !r_active[r_idx];
    assign w_any_match = r_match_found || w_cur_match;
    assign w_any_free  = r_free_found  || w_cur_free;
    assign w_match_sel = r_match_found ? r_match_idx : r_idx;
    assign w_free_sel  = r_free_found  ? r_free_idx  : r_idx;
    assign w_steal     = !w_any_match && !w_any_free;

    always_comb begin
        w_target = w_oldest;
        if (w_any_match) begin
            w_target = w_match_sel;
        end else if (w_any_free) begin
            w_target = w_free_sel;
        end
    end

    voice_age_tracker #(
        .NUM_VOICES (NUM_VOICES),
        .VW         (VW)
    ) u_age (
        .i_clk         (i_sys_clk),
        .i_rst         (i_rst),
        .i_promote     (w_decide && r_ev_on),
        .i_promote_idx (w_target),
        .i_reset_order (w_flush_wr && w_last_idx),
        .o_oldest_idx  (w_oldest)
    );

    // ---------------- datapath ----------------
    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            r_idx         <= '0;
            r_ev_on       <= 1'b0;
            r_ev_note     <= '0;
            r_ev_vel      <= '0;
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_match_idx   <= '0;
            r_free_idx    <= '0;
            r_active      <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_note[i] <= '0;
            end
            r_cfg_valid   <= 1'b0;
            r_cfg_voice   <= '0;
            r_cfg_note    <= '0;
            r_cfg_vel     <= '0;
            r_cfg_gate    <= 1'b0;
            r_steal       <= 1'b0;
        end else begin
            r_cfg_valid <= 1'b0;
            r_steal     <= 1'b0;

            if (w_ev_ready) begin
                r_idx <= '0;
            end

            if (w_latch) begin
                // Velocity-0 note-on is a note-off in MIDI running-status practice.
                r_ev_on       <= i_ev_note_on && (i_ev_vel != '0);
                r_ev_note     <= i_ev_note;
                r_ev_vel      <= i_ev_vel;
                r_match_found <= 1'b0;
                r_free_found  <= 1'b0;
            end

            if (w_scan) begin
                r_idx <= r_idx + VW'(1);
                if (!r_match_found && w_cur_match) begin
                    r_match_found <= 1'b1;
                    r_match_idx   <= r_idx;
                end
                if (!r_free_found && w_cur_free) begin
                    r_free_found <= 1'b1;
                    r_free_idx   <= r_idx;
                end
            end

            if (w_decide) begin
                if (r_ev_on) begin
                    r_active[w_target] <= 1'b1;
                    r_note[w_target]   <= r_ev_note;
                    r_cfg_valid        <= 1'b1;
                    r_cfg_voice        <= w_target;
                    r_cfg_note         <= r_ev_note;
                    r_cfg_vel          <= r_ev_vel;
                    r_cfg_gate         <= 1'b1;
                    r_steal            <= w_steal;
                end else if (w_any_match) begin
                    r_active[w_match_sel] <= 1'b0;
                    r_cfg_valid           <= 1'b1;
                    r_cfg_voice           <= w_match_sel;
                    r_cfg_note            <= r_note[w_match_sel];
                    r_cfg_vel             <= '0;
                    r_cfg_gate            <= 1'b0;
                end
            end

            if (w_flush_wr) begin
                r_idx           <= r_idx + VW'(1);
                r_active[r_idx] <= 1'b0;
                r_cfg_valid     <= 1'b1;
                r_cfg_voice     <= r_idx;
                r_cfg_note      <= '0;
                r_cfg_vel       <= '0;
                r_cfg_gate      <= 1'b0;
            end
        end
    end

    assign o_ev_ready     = w_ev_ready;
    assign o_cfg_valid    = r_cfg_valid;
    assign o_cfg_voice    = r_cfg_voice;
    assign o_cfg_note     = r_cfg_note;
    assign o_cfg_vel      = r_cfg_vel;
    assign o_cfg_gate     = r_cfg_gate;
    assign o_voice_active = r_active;
    assign o_steal_pulse  = r_steal;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Testbench for midi_voice_allocator: directed plus randomized events against a queue-based age model.
// Latency: expected writes carry their due cycle (accept+5, flush+2..+5).
// Backpressure: driver holds events until o_ev_ready; monitor checks every cfg strobe.
module tb_midi_voice_allocator;

    localparam int NV  = 4;
    localparam int VWL = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ev_valid = 1'b0;
    logic           ev_note_on = 1'b0;
    logic [6:0]     ev_note = '0;
    logic [6:0]     ev_vel = '0;
    logic           all_off = 1'b0;
    logic           ev_ready;
    logic           cfg_valid;
    logic [VWL-1:0] cfg_voice;
    logic [6:0]     cfg_note;
    logic [6:0]     cfg_vel;
    logic           cfg_gate;
    logic [NV-1:0]  voice_active;
    logic           steal_pulse;

    midi_voice_allocator #(.NUM_VOICES(NV), .VW(VWL)) dut (
        .i_sys_clk      (clk),
        .i_rst          (rst),
        .i_ev_valid     (ev_valid),
        .o_ev_ready     (ev_ready),
        .i_ev_note_on   (ev_note_on),
        .i_ev_note      (ev_note),
        .i_ev_vel       (ev_vel),
        .i_all_off      (all_off),
        .o_cfg_valid    (cfg_valid),
        .o_cfg_voice    (cfg_voice),
        .o_cfg_note     (cfg_note),
        .o_cfg_vel      (cfg_vel),
        .o_cfg_gate     (cfg_gate),
        .o_voice_active (voice_active),
        .o_steal_pulse  (steal_pulse)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    function automatic void check(input string nm, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        int             due;
        logic [VWL-1:0] voice;
        logic [6:0]     note;
        logic [6:0]     vel;
        logic           gate;
        logic           steal;
    } exp_t;

    exp_t sbq[$];

    // ---------------- reference model ----------------
    // Age is an ordered list of voice indices, oldest first.
    logic       m_active [NV];
    logic [6:0] m_note   [NV];
    int         m_order[$];

    function automatic void model_reset();
        m_order = {};
        for (int i = 0; i < NV; i++) begin
            m_active[i] = 1'b0;
            m_note[i]   = '0;
            m_order.push_back(i);
        end
    endfunction

    function automatic logic [NV-1:0] model_mask();
        logic [NV-1:0] m;
        for (int i = 0; i < NV; i++) m[i] = m_active[i];
        return m;
    endfunction

    function automatic void model_event(input logic on, input logic [6:0] n, input logic [6:0] v, input int acc);
        int   tgt;
        logic stl;
        exp_t e;
        tgt = -1;
        stl = 1'b0;
        if (v == 7'd0) on = 1'b0;
        for (int i = 0; i < NV; i++)
            if (tgt < 0 && m_active[i] && m_note[i] == n) tgt = i;
        if (on) begin
            for (int i = 0; i < NV; i++)
                if (tgt < 0 && !m_active[i]) tgt = i;
            if (tgt < 0) begin
                tgt = m_order[0];
                stl = 1'b1;
            end
            m_active[tgt] = 1'b1;
            m_note[tgt]   = n;
            for (int k = 0; k < m_order.size(); k++) begin
                if (m_order[k] == tgt) begin
                    m_order.delete(k);
                    break;
                end
            end
            m_order.push_back(tgt);
            e.due = acc + NV + 1; e.voice = VWL'(tgt); e.note = n; e.vel = v; e.gate = 1'b1; e.steal = stl;
            sbq.push_back(e);
        end else if (tgt >= 0) begin
            m_active[tgt] = 1'b0;
            e.due = acc + NV + 1; e.voice = VWL'(tgt); e.note = m_note[tgt]; e.vel = '0; e.gate = 1'b0; e.steal = 1'b0;
            sbq.push_back(e);
        end
    endfunction

    function automatic void model_flush(input int f);
        exp_t e;
        for (int i = 0; i < NV; i++) begin
            e.due = f + 2 + i; e.voice = VWL'(i); e.note = '0; e.vel = '0; e.gate = 1'b0; e.steal = 1'b0;
            sbq.push_back(e);
            m_active[i] = 1'b0;
        end
        m_order = {};
        for (int i = 0; i < NV; i++) m_order.push_back(i);
    endfunction

    // ---------------- monitor ----------------
    exp_t           mon_e;
    logic [VWL-1:0] l_voice;
    logic [6:0]     l_note, l_vel;
    logic           l_gate;

    always @(negedge clk) begin
        if (rst) begin
            l_voice = '0; l_note = '0; l_vel = '0; l_gate = 1'b0;
        end else if (cfg_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_cfg: voice=%0d note=%0d vel=%0d gate=%0b at cycle %0d, none expected",
                         cfg_voice, cfg_note, cfg_vel, cfg_gate, cyc);
            end else begin
                mon_e = sbq.pop_front();
                checks++;
                if (cyc != mon_e.due || cfg_voice !== mon_e.voice || cfg_note !== mon_e.note ||
                    cfg_vel !== mon_e.vel || cfg_gate !== mon_e.gate || steal_pulse !== mon_e.steal) begin
                    failures++;
                    $display("FAIL cfg_write: got cyc=%0d voice=%0d note=%0d vel=%0d gate=%0b steal=%0b expected cyc=%0d voice=%0d note=%0d vel=%0d gate=%0b steal=%0b",
                             cyc, cfg_voice, cfg_note, cfg_vel, cfg_gate, steal_pulse,
                             mon_e.due, mon_e.voice, mon_e.note, mon_e.vel, mon_e.gate, mon_e.steal);
                end
            end
            l_voice = cfg_voice; l_note = cfg_note; l_vel = cfg_vel; l_gate = cfg_gate;
        end else begin
            check("cfg_hold", {cfg_voice, cfg_note, cfg_vel, cfg_gate}, {l_voice, l_note, l_vel, l_gate});
            check("steal_without_write", steal_pulse, 0);
        end
    end

    // ---------------- driver ----------------
    task automatic send_event(input logic on, input logic [6:0] n, input logic [6:0] v, output int acc);
        int budget;
        @(posedge clk); #1;
        ev_valid = 1'b1; ev_note_on = on; ev_note = n; ev_vel = v;
        acc = -1;
        budget = 0;
        while (acc < 0 && budget < 40) begin
            @(negedge clk);
            if (ev_ready && !all_off) acc = cyc;
            else budget++;
        end
        if (acc < 0) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: ev_ready stayed %0b, required 1 within 40 cycles", ev_ready);
            ev_valid = 1'b0;
            return;
        end
        model_event(on, n, v, acc);
        @(posedge clk); #1;
        ev_valid = 1'b0;
        while (cyc < acc + NV + 2) begin
            @(negedge clk);
            if (cyc == acc + NV + 1) check("busy_in_commit", ev_ready, 0);
        end
        check("ready_after_event", ev_ready, 1);
        check("voice_active", voice_active, model_mask());
    endtask

    task automatic do_flush(input logic on, input logic [6:0] n, input logic [6:0] v);
        int f;
        int acc;
        @(posedge clk); #1;
        all_off = 1'b1;
        ev_valid = 1'b1; ev_note_on = on; ev_note = n; ev_vel = v;
        @(negedge clk);
        f = cyc;
        check("ready_at_flush_start", ev_ready, 1);
        model_flush(f);
        @(posedge clk); #1;
        all_off = 1'b0;
        send_event(on, n, v, acc);
        check("accept_after_flush", acc, f + NV + 1);
    endtask

    task automatic reset_mid_scan();
        @(posedge clk); #1;
        ev_valid = 1'b1; ev_note_on = 1'b1; ev_note = 7'd61; ev_vel = 7'd50;
        @(negedge clk);
        check("scan_abort_accept", ev_ready, 1);
        @(posedge clk); #1;
        ev_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        sbq.delete();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", ev_ready, 1);
        check("post_reset_cfg", {cfg_valid, cfg_voice, cfg_note, cfg_vel, cfg_gate, steal_pulse}, 0);
        check("post_reset_active", voice_active, 0);
        repeat (8) @(negedge clk);
    endtask

    // ---------------- main ----------------
    initial begin
        int acc;
        logic       r_on;
        logic [6:0] r_n, r_v;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", ev_ready, 1);
        check("reset_cfg", {cfg_valid, cfg_voice, cfg_note, cfg_vel, cfg_gate, steal_pulse}, 0);
        check("reset_active", voice_active, 0);

        // Fill voices, then steal the oldest.
        send_event(1'b1, 7'd60, 7'd100, acc);
        send_event(1'b1, 7'd62, 7'd90,  acc);
        send_event(1'b1, 7'd64, 7'd80,  acc);
        send_event(1'b1, 7'd65, 7'd70,  acc);
        send_event(1'b1, 7'd67, 7'd60,  acc);
        // Retrigger a held note, then release paths.
        send_event(1'b1, 7'd62, 7'd55,  acc);
        send_event(1'b0, 7'd64, 7'd40,  acc);
        send_event(1'b0, 7'd70, 7'd40,  acc);
        send_event(1'b1, 7'd50, 7'd0,   acc);
        send_event(1'b1, 7'd69, 7'd33,  acc);
        send_event(1'b1, 7'd71, 7'd22,  acc);
        // Panic with an event waiting, then confirm age order restarts at 0..3.
        do_flush(1'b1, 7'd72, 7'd90);
        send_event(1'b1, 7'd74, 7'd11, acc);
        send_event(1'b1, 7'd75, 7'd12, acc);
        send_event(1'b1, 7'd76, 7'd13, acc);
        send_event(1'b1, 7'd77, 7'd14, acc);
        send_event(1'b1, 7'd78, 7'd15, acc);

        reset_mid_scan();

        for (int i = 0; i < 200; i++) begin
            r_on = ($urandom_range(0, 9) < 7);
            r_n  = 7'($urandom_range(60, 67));
            r_v  = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            if ($urandom_range(0, 24) == 0) do_flush(r_on, r_n, r_v);
            else send_event(r_on, r_n, r_v, acc);
        end

        repeat (10) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
